ber_checker: RTL and testbench

//  Downstream of the slicer: compares recovered bits against the transmitted PRBS reference.

---
 rtl/ber_pkg.sv | 25 ++
 rtl/ber_checker_delay.sv | 28 ++
 rtl/ber_checker.sv | 183 ++++++++++++++++++
 tb/tb_ber_checker.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER checker: FSM states, clog2, saturating add.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clamps at maxv instead of wrapping; callers truncate to their counter width.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] maxv);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, maxv}) ? maxv : s[63:0];
  endfunction

endpackage

// File: rtl/ber_checker_delay.sv
// Reference history for the BER checker: shift register of past PRBS bits plus the
// delay-select mux (d=0 is the live bit, d>0 is the bit seen d strobes ago).
module prbs_delay_line
  import ber_pkg::*;
#(
  parameter int DLY_MAX = 64,
  parameter int W_DLY   = 6
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_strobe,
  input  logic             i_prbs,
  input  logic [W_DLY-1:0] i_dly,
  output logic             o_ref
);

  logic [DLY_MAX-2:0] hist_q;
  logic [DLY_MAX-1:0] taps;

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset)       hist_q <= '0;
    else if (i_strobe) hist_q <= {hist_q[DLY_MAX-3:0], i_prbs};
  end

  assign taps  = {hist_q, i_prbs};
  assign o_ref = taps[i_dly];

endmodule

// File: rtl/ber_checker.sv
// BER checker: fills the reference history, sweeps all delays for the minimum-error
// window, then locks and accumulates saturating bit/error counts.
// Optional BER_RELOCK_EN: a locked window with more than WIN/4 errors restarts the sweep.
module ber_checker
  import ber_pkg::*;
#(
  parameter int DLY_MAX = 64,
  parameter int W_DLY   = 6,
  parameter int WIN     = 511,
  parameter int CNT_W   = 32
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic             i_slicer,
  input  logic             i_prbs,
  input  logic             i_clear,
  output logic             o_locked,
  output logic [W_DLY-1:0] o_delay,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  // One spare bit so the "no best yet" value always exceeds any real window count.
  localparam int              WIN_W   = clog2(WIN + 1) + 1;
  localparam logic [W_DLY-1:0] D_LAST = W_DLY'(DLY_MAX - 1);
  localparam logic [WIN_W-1:0] W_LAST = WIN_W'(WIN - 1);
  localparam logic [63:0]     CNT_MAX = 64'((65'd1 << CNT_W) - 65'd1);

  state_e           state_q, state_d;
  logic [W_DLY-1:0] fill_q, fill_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] win_err_q, win_err_d;
  logic [W_DLY-1:0] cand_q, cand_d;
  logic [W_DLY-1:0] best_dly_q, best_dly_d;
  logic [WIN_W-1:0] best_err_q, best_err_d;
  logic [W_DLY-1:0] delay_q, delay_d;
  logic             locked_q, locked_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic             strobe, ref_bit, err, win_end, new_best;
  logic [W_DLY-1:0] dly_sel;
  logic [WIN_W-1:0] win_tot;

  assign strobe  = i_enable & i_valid;
  assign dly_sel = (state_q == ST_SEARCH) ? cand_q : delay_q;

  // A clear swallows a same-cycle strobe, so history does not advance either.
  prbs_delay_line #(.DLY_MAX(DLY_MAX), .W_DLY(W_DLY)) u_dly (
    .clock   (clock),
    .i_reset (i_reset),
    .i_strobe(strobe & ~i_clear),
    .i_prbs  (i_prbs),
    .i_dly   (dly_sel),
    .o_ref   (ref_bit)
  );

  assign err      = i_slicer ^ ref_bit;
  assign win_tot  = win_err_q + {{(WIN_W-1){1'b0}}, err};
  assign win_end  = (win_cnt_q == W_LAST);
  assign new_best = (win_tot < best_err_q);

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    cand_d     = cand_q;
    best_dly_d = best_dly_q;
    best_err_d = best_err_q;
    delay_d    = delay_q;
    locked_d   = locked_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (i_clear) begin
      state_d    = ST_FILL;
      fill_d     = '0;
      win_cnt_d  = '0;
      win_err_d  = '0;
      cand_d     = '0;
      best_dly_d = '0;
      best_err_d = '1;
      delay_d    = '0;
      locked_d   = 1'b0;
      bit_cnt_d  = '0;
      err_cnt_d  = '0;
    end else if (strobe) begin
      case (state_q)
        ST_FILL: begin
          if (fill_q == D_LAST) begin
            state_d    = ST_SEARCH;
            fill_d     = '0;
            win_cnt_d  = '0;
            win_err_d  = '0;
            cand_d     = '0;
            best_dly_d = '0;
            best_err_d = '1;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        ST_SEARCH: begin
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (new_best) begin
              best_err_d = win_tot;
              best_dly_d = cand_q;
            end
            if (cand_q == D_LAST) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
              delay_d  = new_best ? cand_q : best_dly_q;
            end else begin
              cand_d = cand_q + 1'b1;
            end
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_tot;
          end
        end
        ST_LOCKED: begin
          bit_cnt_d = CNT_W'(sat_add(64'(bit_cnt_q), 64'd1, CNT_MAX));
          err_cnt_d = CNT_W'(sat_add(64'(err_cnt_q), 64'(err), CNT_MAX));
`ifdef BER_RELOCK_EN
          // Accumulators are held across a relock so the link history survives.
          if (win_end) begin
            win_cnt_d = '0;
            win_err_d = '0;
            if (win_tot > WIN_W'(WIN / 4)) begin
              state_d    = ST_SEARCH;
              locked_d   = 1'b0;
              cand_d     = '0;
              best_dly_d = '0;
              best_err_d = '1;
            end
          end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            win_err_d = win_tot;
          end
`endif
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_FILL;
      fill_q     <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      cand_q     <= '0;
      best_dly_q <= '0;
      best_err_q <= '1;
      delay_q    <= '0;
      locked_q   <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      cand_q     <= cand_d;
      best_dly_q <= best_dly_d;
      best_err_q <= best_err_d;
      delay_q    <= delay_d;
      locked_q   <= locked_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign o_locked  = locked_q;
  assign o_delay   = delay_q;
  assign o_bit_cnt = bit_cnt_q;
  assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// Directed bench for ber_checker (DLY_MAX=8, WIN=16): a phase table of PRBS9 stimulus
// with expected lock/delay/counts, plus hand sequences for clear, reset and relock.
module tb_ber_checker;

  logic        clock = 1'b0;
  logic        i_reset, i_enable, i_valid, i_slicer, i_prbs, i_clear;
  logic        o_locked, locked2;
  logic [2:0]  o_delay, delay2;
  logic [15:0] o_bit_cnt, o_err_cnt;
  logic [3:0]  bit2, err2;

  int nvec = 0;
  int nerr = 0;

  logic [8:0]  lfsr    = 9'h1FF;
  logic [15:0] tb_hist = '0;

  always #5 clock = ~clock;

  ber_checker #(.DLY_MAX(8), .W_DLY(3), .WIN(16), .CNT_W(16)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_slicer(i_slicer), .i_prbs(i_prbs), .i_clear(i_clear),
    .o_locked(o_locked), .o_delay(o_delay), .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt));

  ber_checker #(.DLY_MAX(8), .W_DLY(3), .WIN(16), .CNT_W(4)) dut_sat (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_slicer(i_slicer), .i_prbs(i_prbs), .i_clear(i_clear),
    .o_locked(locked2), .o_delay(delay2), .o_bit_cnt(bit2), .o_err_cnt(err2));

  typedef struct {
    int n;       // strobes in this phase
    int src;     // slicer = prbs delayed src strobes
    int cnst;    // 1: prbs held 0, slicer held 1 (every delay mismatches)
    int flip;    // invert slicer every flip-th strobe (0 = never)
    int gap;     // insert 10 disabled cycles before this strobe index (0 = none)
    int e_lock;
    int e_dly;
    int e_bit;
    int e_err;   // -1 = not checked from the table
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic send(input int src, input int cnst, input bit flip);
    logic p, s;
    @(negedge clock);
    if (cnst != 0) p = 1'b0;
    else begin
      p    = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], p};
    end
    s = (cnst != 0) ? 1'b1 : ((src == 0) ? p : tb_hist[src-1]);
    s = s ^ flip;
    tb_hist  = {tb_hist[14:0], p};
    i_enable = 1'b1; i_valid = 1'b1; i_clear = 1'b0;
    i_prbs   = p;    i_slicer = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      i_valid = 1'b0; i_clear = 1'b0; i_enable = 1'b1;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clock);
      i_enable = 1'b0; i_valid = 1'b1;
      i_prbs = 1'($urandom); i_slicer = 1'($urandom);
    end
  endtask

  task automatic clear_pulse(input bit with_strobe);
    @(negedge clock);
    i_clear = 1'b1; i_enable = 1'b1; i_valid = with_strobe;
    i_prbs = 1'b1; i_slicer = 1'b0;
    idle(1);
  endtask

  task automatic apply(input int lo, input int hi);
    for (int v = lo; v <= hi; v++) begin
      for (int k = 0; k < tbl[v].n; k++) begin
        if (tbl[v].gap > 0 && k == tbl[v].gap) gap(10);
        send(tbl[v].src, tbl[v].cnst, tbl[v].flip > 0 && ((k + 1) % tbl[v].flip) == 0);
      end
      idle(1);
      chk($sformatf("v%0d_locked", v), o_locked, tbl[v].e_lock);
      chk($sformatf("v%0d_delay", v), o_delay, tbl[v].e_dly);
      chk($sformatf("v%0d_bit_cnt", v), o_bit_cnt, tbl[v].e_bit);
      if (tbl[v].e_err >= 0) chk($sformatf("v%0d_err_cnt", v), o_err_cnt, tbl[v].e_err);
    end
  endtask

  task automatic async_reset_check(input string tag);
    @(negedge clock);
    #2 i_reset = 1'b1;
    #1;
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_delay"}, o_delay, 0);
    chk({tag, "_bit_cnt"}, o_bit_cnt, 0);
    chk({tag, "_err_cnt"}, o_err_cnt, 0);
    @(negedge clock);
    i_reset = 1'b0;
  endtask

  initial begin
    //           n   src cnst flip gap lock dly  bit    err
    tbl[0] = '{ 135, 5,  0,   0,   0,  0,   0,   0,     0 };
    tbl[1] = '{   1, 5,  0,   0,   0,  1,   5,   0,     0 };
    tbl[2] = '{1000, 5,  0,   0,   0,  1,   5,   1000,  0 };
    tbl[3] = '{1000, 5,  0,   100, 0,  1,   5,   2000,  10 };
    tbl[4] = '{ 136, 5,  0,   0,   0,  1,   5,   0,     0 };
    tbl[5] = '{ 136, 0,  1,   0,   0,  1,   0,   0,     0 };
    tbl[6] = '{  15, 0,  1,   0,   0,  1,   0,   15,    15 };
    tbl[7] = '{  61, 5,  0,   0,   0,  0,   0,   0,     0 };
    tbl[8] = '{ 136, 5,  0,   0,   70, 1,   5,   0,     0 };

    i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0;
    i_slicer = 1'b0; i_prbs = 1'b0; i_clear = 1'b0;
    repeat (3) @(negedge clock);
    i_reset = 1'b0;
    chk("reset_locked", o_locked, 0);
    chk("reset_delay", o_delay, 0);
    chk("reset_bit_cnt", o_bit_cnt, 0);
    chk("reset_err_cnt", o_err_cnt, 0);

    // Lock at delay 5, clean run, then one injected error per 100 strobes.
    apply(0, 3);
    chk("sat_bit_cnt", bit2, 15);
    chk("sat_err_cnt", err2, 10);
    chk("sat_locked", locked2, 1);
    chk("sat_delay", delay2, 5);

    // Clear wins over a same-cycle strobe, then relock at 5.
    clear_pulse(1'b1);
    chk("clr_locked", o_locked, 0);
    chk("clr_bit_cnt", o_bit_cnt, 0);
    chk("clr_err_cnt", o_err_cnt, 0);
    apply(4, 4);

    // Every delay ties at a full window of errors: lowest delay wins.
    clear_pulse(1'b0);
    apply(5, 6);

    // Reset mid-sweep (candidate 3), then a full sweep with a disabled gap.
    clear_pulse(1'b0);
    apply(7, 7);
    async_reset_check("rst_search");
    apply(8, 8);

    // Channel delay changes from 5 to 3 while locked.
`ifdef BER_RELOCK_EN
    begin
      int k;
      k = 0;
      while (o_locked && k < 200) begin
        send(3, 0, 1'b0);
        k++;
      end
      chk("relock_dropped", o_locked, 0);
      for (int j = 0; j < 130; j++) send(3, 0, 1'b0);
      idle(1);
      chk("relock_locked", o_locked, 1);
      chk("relock_delay", o_delay, 3);
    end
`else
    for (int j = 0; j < 64; j++) send(3, 0, 1'b0);
    idle(1);
    chk("shift_locked", o_locked, 1);
    chk("shift_delay", o_delay, 5);
    chk("shift_bit_cnt", o_bit_cnt, 64);
    chk("shift_err_range", (o_err_cnt >= 16 && o_err_cnt <= 48), 1);
`endif

    async_reset_check("rst_locked");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
